a2d_scan: RTL and testbench
===========================

Name: a2d_scan

Overview:
Autonomous ADC scan controller that sequences the SPI monarch (SPI_mnrch) against the ADC128S.
- Periodically walks a fixed list of 4 ADC channels and issues the SPI command pair for each channel.
- Captures each 12-bit conversion into a per-channel holding register.
- Flags a timeout if the SPI monarch never reports done.
- Sits between SPI_mnrch (drives its snd/cmd, consumes its done/resp) and the e-bike sensing logic (battery, torque, brake, etc.).

Parameters:
- CH0, 3'd0, ADC channel scanned in slot 0
- CH1, 3'd1, ADC channel scanned in slot 1
- CH2, 3'd4, ADC channel scanned in slot 2
- CH3, 3'd5, ADC channel scanned in slot 3
- PERIOD_CYC, 16384, idle clocks between end of one round and start of the next (>=2)
- TO_CYC, 4096, max clocks waiting for done per transaction before error (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- en  in  1  scanning enable
- snd  out  1  one-cycle start pulse to SPI_mnrch
- cmd  out  16  SPI command to SPI_mnrch
- done  in  1  SPI_mnrch transaction-complete pulse
- resp  in  16  SPI_mnrch response word
- rd0, rd1, rd2, rd3  out  12 each  latest reading for slots 0..3
- rd_vld  out  1  one-cycle strobe: a reading register was just updated
- rd_idx  out  2  slot updated when rd_vld=1
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset values: snd=0, cmd=16'h0000, rd0..rd3=0, rd_vld=0, rd_idx=0, busy=0, err=0, state=IDLE, slot=0, period counter=0.
- cmd encoding: {2'b00, CHn, 11'h000}.
- The ADC128S is pipelined (a response carries the channel addressed in the previous transaction). Each slot therefore does two transactions with the same cmd; only the second resp is kept.
- States: IDLE, SND1, WAIT1, SND2, WAIT2, NEXT.
- IDLE:
  - Period counter increments while en=1 and clears while en=0.
  - When counter == PERIOD_CYC-1 and en=1: clear counter, slot=0, go to SND1.
- SND1 / SND2:
  - snd=1 for exactly this cycle.
  - cmd is registered on entry to SND1 and held stable until the slot finishes.
  - Timeout counter cleared. Next state is WAIT1 / WAIT2.
- WAIT1: done=1 -> SND2 (one idle cycle minimum between transactions is provided by the SND state).
- WAIT2: done=1 -> at that edge:
  - rd[slot] <= resp[11:0]
  - rd_vld <= 1 and rd_idx <= slot for exactly one cycle
  - go to NEXT
- NEXT:
  - slot==3 -> IDLE (counter starts from 0).
  - Otherwise slot+1 -> SND1.
- Timeout: in WAIT1/WAIT2 the timeout counter increments each cycle. On reaching TO_CYC-1 with no done:
  - err <= 1, go to IDLE, slot=0.
  - Reading registers are unchanged and rd_vld is not pulsed.
- done seen in any state other than WAIT1/WAIT2 is ignored. done coinciding with the timeout terminal count counts as success (done wins).
- en deasserted mid-round: the current round completes through slot 3, then the block stays in IDLE.
- Reset asserted mid-round: at the next edge all state returns to reset values, with no further snd. SPI_mnrch shares rst_n.
- rd_vld and snd are never high in the same cycle.
- resp[15:12] is ignored.
- Latency from round start (IDLE exit) to the first rd_vld is 2 + 2*(SPI transaction length) + 1 cycles.

Decomposition:
- Package a2d_scan_pkg:
  - state enum type
  - CMD_HDR=2'b00, CMD_PAD=11'h000
  - NUM_SLOTS=4, RD_W=12
- One sub-module: cyc_timer, a clearable up-counter with enable and a terminal-count output, parameterised by terminal value.
  - Instantiated twice: period counter and timeout counter.

Test Plan:
- Bench uses a scripted SPI responder stub: it pulses done 40 cycles after each snd and returns scripted resp.
- Reset then en=1, PERIOD_CYC=16 -> first snd exactly 16 cycles after en rises; cmd=16'h0000 on both slot-0 transactions.
- Full round, stub resps per slot (2nd txn) = 16'h0C00, 16'h0C01, 16'h0BF1, 16'h0BF4 -> rd0=12'hC00, rd1=12'hC01, rd2=12'hBF1, rd3=12'hBF4.
  - Four rd_vld pulses with rd_idx=0,1,2,3.
  - cmds 16'h0000, 16'h0800, 16'h2000, 16'h2800.
  - busy drops the cycle after slot 3 NEXT.
- Stub returns 16'hF123 on 2nd txn -> rd0=12'h123 (upper nibble discarded).
- TO_CYC=64, stub never pulses done -> err=1 at 64 cycles after SND1, state IDLE, rd0..rd3 unchanged, no rd_vld. The next round still runs normally.
- en dropped during slot 1 -> slots 1..3 complete, then no further snd for 3*PERIOD_CYC.
- rst_n low for 1 cycle during WAIT2 of slot 2 -> all outputs at reset values the next cycle; no rd_vld; the next round restarts at slot 0.

Source files
------------

// File: rtl/a2d_scan_pkg.sv
// Shared types and constants for the ADC128S scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a2d_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SND1,
        ST_WAIT1,
        ST_SND2,
        ST_WAIT2,
        ST_NEXT
    } state_t;

    localparam logic [1:0]  CMD_HDR   = 2'b00;
    localparam logic [10:0] CMD_PAD   = 11'h000;
    localparam int          NUM_SLOTS = 4;
    localparam int          RD_W      = 12;

    // ADC128S control word: channel address sits in bits [13:11]
    function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
        return {CMD_HDR, ch, CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_scan_cyc_timer.sv
// Clearable up-counter with enable; o_tc is high while the count equals TERM.
// Latency: count updates one clock after i_inc; o_tc is a decode of the count.
// Backpressure: none; the count holds at TERM until cleared.
module cyc_timer #(
    parameter int TERM = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int             W      = $clog2(TERM + 2);
    localparam logic [W-1:0]   TERM_V = W'(TERM);

    logic [W-1:0] r_cnt;

    // Count up while enabled, clear has priority, saturate at the terminal value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != TERM_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TERM_V);

endmodule

// File: rtl/a2d_scan.sv
// Periodic 4-slot ADC128S scanner driving SPI_mnrch; keeps the 2nd response of each slot.
// Latency: first rd_vld ~2 SPI transactions after round start; snd/rd_vld are registered.
// Backpressure: waits on done per transaction; a missing done sets sticky err and aborts the round.
module a2d_scan
    import a2d_scan_pkg::*;
#(
    parameter logic [2:0] CH0        = 3'd0,
    parameter logic [2:0] CH1        = 3'd1,
    parameter logic [2:0] CH2        = 3'd4,
    parameter logic [2:0] CH3        = 3'd5,
    parameter int         PERIOD_CYC = 16384,
    parameter int         TO_CYC     = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            snd,
    output logic [15:0]     cmd,
    input  logic            done,
    input  logic [15:0]     resp,
    output logic [RD_W-1:0] rd0,
    output logic [RD_W-1:0] rd1,
    output logic [RD_W-1:0] rd2,
    output logic [RD_W-1:0] rd3,
    output logic            rd_vld,
    output logic [1:0]      rd_idx,
    output logic            busy,
    output logic            err
);

    localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);

    state_t          r_state;
    logic [1:0]      r_slot;
    logic [15:0]     r_cmd;
    logic            r_snd;
    logic            r_rd_vld;
    logic [1:0]      r_rd_idx;
    logic            r_err;
    logic [RD_W-1:0] r_rd [NUM_SLOTS];

    logic w_per_tc;
    logic w_per_clr;
    logic w_to_tc;
    logic w_in_wait;
    logic w_resp_hi_unused;

    function automatic logic [2:0] slot_ch(input logic [1:0] s);
        case (s)
            2'd0:    return CH0;
            2'd1:    return CH1;
            2'd2:    return CH2;
            default: return CH3;
        endcase
    endfunction

    assign w_in_wait        = (r_state == ST_WAIT1) || (r_state == ST_WAIT2);
    assign w_per_clr        = (r_state != ST_IDLE) || !en || w_per_tc;
    assign w_resp_hi_unused = ^resp[15:12];

    // Idle-gap counter between rounds; only runs in IDLE with en high
    cyc_timer #(.TERM(PERIOD_CYC - 1)) u_period (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_per_clr),
        .i_inc   (en),
        .o_tc    (w_per_tc)
    );

    // Done watchdog; terminal is TO_CYC-2 so the abort lands on the edge where
    // the count would reach TO_CYC-1 (cleared in the SND cycle before each wait)
    cyc_timer #(.TERM(TO_CYC - 2)) u_timeout (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (!w_in_wait),
        .i_inc   (1'b1),
        .o_tc    (w_to_tc)
    );

    // Scan sequencer: two identical transactions per slot, second response kept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_slot   <= '0;
            r_cmd    <= '0;
            r_snd    <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_rd[i] <= '0;
            end
        end else begin
            r_snd    <= 1'b0;
            r_rd_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en && w_per_tc) begin
                        r_slot  <= '0;
                        r_cmd   <= mk_cmd(CH0);
                        r_snd   <= 1'b1;
                        r_state <= ST_SND1;
                    end
                end
                ST_SND1: r_state <= ST_WAIT1;
                ST_WAIT1: begin
                    // done wins over a coincident timeout
                    if (done) begin
                        r_snd   <= 1'b1;
                        r_state <= ST_SND2;
                    end else if (w_to_tc) begin
                        r_err   <= 1'b1;
                        r_slot  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SND2: r_state <= ST_WAIT2;
                ST_WAIT2: begin
                    if (done) begin
                        r_rd[r_slot] <= resp[RD_W-1:0];
                        r_rd_vld     <= 1'b1;
                        r_rd_idx     <= r_slot;
                        r_state      <= ST_NEXT;
                    end else if (w_to_tc) begin
                        r_err   <= 1'b1;
                        r_slot  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (r_slot == LAST_SLOT) begin
                        r_slot  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_slot  <= r_slot + 1'b1;
                        r_cmd   <= mk_cmd(slot_ch(r_slot + 1'b1));
                        r_snd   <= 1'b1;
                        r_state <= ST_SND1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign snd    = r_snd;
    assign cmd    = r_cmd;
    assign rd0    = r_rd[0];
    assign rd1    = r_rd[1];
    assign rd2    = r_rd[2];
    assign rd3    = r_rd[3];
    assign rd_vld = r_rd_vld;
    assign rd_idx = r_rd_idx;
    assign busy   = (r_state != ST_IDLE);
    assign err    = r_err;

endmodule

// File: tb/tb_a2d_scan.sv
// Self-checking bench for a2d_scan with a scripted SPI_mnrch responder stub.
// Latency: stub answers 40 clocks after each snd.
// Backpressure: stub can be muted to exercise the done timeout.
module tb_a2d_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic [11:0] rd0, rd1, rd2, rd3;
    logic        rd_vld;
    logic [1:0]  rd_idx;
    logic        busy;
    logic        err;

    a2d_scan #(.PERIOD_CYC(16), .TO_CYC(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .snd    (snd),
        .cmd    (cmd),
        .done   (done),
        .resp   (resp),
        .rd0    (rd0),
        .rd1    (rd1),
        .rd2    (rd2),
        .rd3    (rd3),
        .rd_vld (rd_vld),
        .rd_idx (rd_idx),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] resp;
        logic [15:0] cmd;
        logic [11:0] rd;
    } vec_t;

    vec_t        vec [8];
    logic [15:0] resp_tab [4];
    logic        stub_clr;
    logic        stub_mute;
    int          n_chk  = 0;
    int          n_pass = 0;

    logic [15:0] snd_q [$];
    logic [1:0]  vld_q [$];
    int          overlap = 0;

    // Scripted responder: done 40 clocks after snd, 1st txn junk, 2nd txn from table
    int   st_cnt   = 0;
    logic st_phase = 1'b0;
    int   st_slot  = 0;
    initial begin
        done = 1'b0;
        resp = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (stub_clr) begin
                st_cnt   = 0;
                st_phase = 1'b0;
                st_slot  = 0;
            end else begin
                if (st_cnt > 0) begin
                    st_cnt--;
                    if (st_cnt == 0 && !stub_mute) begin
                        done = 1'b1;
                        if (st_phase) begin
                            resp     = resp_tab[st_slot];
                            st_slot  = (st_slot + 1) % 4;
                            st_phase = 1'b0;
                        end else begin
                            resp     = 16'h5A5A;
                            st_phase = 1'b1;
                        end
                    end
                end
                if (snd) st_cnt = 40;
            end
        end
    end

    // Event logger
    initial begin
        forever begin
            @(negedge clk);
            if (snd)           snd_q.push_back(cmd);
            if (rd_vld)        vld_q.push_back(rd_idx);
            if (snd && rd_vld) overlap++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [11:0] get_rd(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic [15:0] qcmd(input int p);
        if (p < snd_q.size()) return snd_q[p];
        return 16'hxxxx;
    endfunction

    function automatic logic [1:0] qvld(input int p);
        if (p < vld_q.size()) return vld_q[p];
        return 2'bxx;
    endfunction

    task automatic load_resp(input int b);
        for (int i = 0; i < 4; i++) resp_tab[i] = vec[b+i].resp;
    endtask

    task automatic wait_snd(input int lim, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!snd && k < lim);
        chk("snd_seen", 32'(snd), 32'd1);
    endtask

    task automatic wait_vld(input logic [1:0] idx, input int lim);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rd_vld && rd_idx == idx) && k < lim);
        chk("rd_vld_seen", 32'(rd_vld && rd_idx == idx), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_snd"},    32'(snd),    32'd0);
        chk({tag, "_cmd"},    32'(cmd),    32'd0);
        chk({tag, "_rd0"},    32'(rd0),    32'd0);
        chk({tag, "_rd1"},    32'(rd1),    32'd0);
        chk({tag, "_rd2"},    32'(rd2),    32'd0);
        chk({tag, "_rd3"},    32'(rd3),    32'd0);
        chk({tag, "_rd_vld"}, 32'(rd_vld), 32'd0);
        chk({tag, "_rd_idx"}, 32'(rd_idx), 32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_err"},    32'(err),    32'd0);
    endtask

    // Wait for the end of a round and check it against table entries b..b+3
    task automatic run_round(input int b, input int sb, input int vb);
        wait_vld(2'd3, 2000);
        chk("busy_in_last_next", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after_round", 32'(busy), 32'd0);
        @(negedge clk);
        chk("round_snd_count", 32'(snd_q.size() - sb), 32'd8);
        chk("round_vld_count", 32'(vld_q.size() - vb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cmd_txn1_slot%0d", i), 32'(qcmd(sb + 2*i)),     32'(vec[b+i].cmd));
            chk($sformatf("cmd_txn2_slot%0d", i), 32'(qcmd(sb + 2*i + 1)), 32'(vec[b+i].cmd));
            chk($sformatf("rd_idx_order%0d", i),  32'(qvld(vb + i)),       32'(i));
            chk($sformatf("rd_slot%0d", i),       32'(get_rd(i)),          32'(vec[b+i].rd));
        end
    endtask

    initial begin
        int k;
        int sb;
        int vb;
        int sn;

        vec[0] = '{16'h0C00, 16'h0000, 12'hC00};
        vec[1] = '{16'h0C01, 16'h0800, 12'hC01};
        vec[2] = '{16'h0BF1, 16'h2000, 12'hBF1};
        vec[3] = '{16'h0BF4, 16'h2800, 12'hBF4};
        vec[4] = '{16'hF123, 16'h0000, 12'h123};
        vec[5] = '{16'h0456, 16'h0800, 12'h456};
        vec[6] = '{16'h8789, 16'h2000, 12'h789};
        vec[7] = '{16'h7ABC, 16'h2800, 12'hABC};

        rst_n = 1'b0; en = 1'b0; stub_clr = 1'b1; stub_mute = 1'b0;
        load_resp(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        stub_clr = 1'b0;

        // Round 1: start delay and baseline values
        sb = snd_q.size(); vb = vld_q.size();
        en = 1'b1;
        wait_snd(100, k);
        chk("first_snd_delay", 32'(k), 32'd16);
        chk("first_cmd", 32'(cmd), 32'h0000);
        chk("busy_in_snd1", 32'(busy), 32'd1);
        run_round(0, sb, vb);

        // Round 2: upper response nibble dropped
        load_resp(4);
        sb = snd_q.size(); vb = vld_q.size();
        run_round(4, sb, vb);

        // Timeout: stub silent
        stub_mute = 1'b1;
        vb = vld_q.size();
        wait_snd(100, k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!err && k < 200);
        chk("err_delay_from_snd1", 32'(k), 32'd64);
        chk("err_set", 32'(err), 32'd1);
        chk("idle_after_timeout", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rd_kept_slot%0d", i), 32'(get_rd(i)), 32'(vec[4+i].rd));
        sb = snd_q.size();
        stub_mute = 1'b0; stub_clr = 1'b1;
        load_resp(0);
        repeat (2) @(negedge clk);
        stub_clr = 1'b0;
        chk("no_vld_on_timeout", 32'(vld_q.size() - vb), 32'd0);
        run_round(0, sb, vb);
        chk("err_sticky", 32'(err), 32'd1);

        // en dropped during slot 1
        load_resp(4);
        sb = snd_q.size(); vb = vld_q.size();
        wait_vld(2'd0, 2000);
        repeat (10) @(negedge clk);
        en = 1'b0;
        run_round(4, sb, vb);
        sn = snd_q.size();
        repeat (48) @(negedge clk);
        chk("no_snd_after_en_drop", 32'(snd_q.size() - sn), 32'd0);
        chk("idle_after_en_drop", 32'(busy), 32'd0);

        // Reset pulse during WAIT2 of slot 2
        load_resp(0);
        en = 1'b1;
        for (int i = 0; i < 6; i++) wait_snd(100, k);
        repeat (10) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0; stub_clr = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        rst_n = 1'b1;
        sb = snd_q.size(); vb = vld_q.size();
        @(negedge clk);
        stub_clr = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_vld_after_reset", 32'(vld_q.size() - vb), 32'd0);
        chk("no_snd_after_reset", 32'(snd_q.size() - sb), 32'd0);
        run_round(0, sb, vb);

        chk("snd_vld_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
